bilinear_coord_generator: RTL and testbench
===========================================

BILINEAR_COORD_GENERATOR -- requirements
Module: bilinear_coord_generator

Interface
REQ-001 Parameter: SCALE_FW, 8, number of fraction bits in the step inputs and offset outputs.
REQ-002 Parameter: W_BITS, 12, width of the integer pixel coordinate and dimension fields.
REQ-003 Port: clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: i_start  input  1  frame start pulse, sampled only in IDLE.
REQ-006 Port: i_src_width / i_src_height  input  W_BITS each  source image size, 2..4095.
REQ-007 Port: i_dst_width / i_dst_height  input  W_BITS each  destination image size, 0..4095.
REQ-008 Port: i_step_x / i_step_y  input  4+SCALE_FW each  unsigned source step per destination pixel (UQ4.SCALE_FW).
REQ-009 Port: i_coord_ready  input  1  downstream accepts the current coordinate.
REQ-010 Port: o_coord_valid  output  1  coordinate outputs hold a valid destination-pixel mapping.
REQ-011 Port: o_src_x / o_src_y  output  W_BITS each  integer source coordinate of the top-left neighbour.
REQ-012 Port: o_offset_x / o_offset_y  output  SCALE_FW each  fractional position inside the 2x2 neighbourhood.
REQ-013 Port: o_line_last / o_frame_last  output  1 each  the current coordinate is the last of its row / frame.
REQ-014 Port: o_busy  output  1  high in RUN and DONE.
REQ-015 Port: o_frame_done  output  1  one-cycle pulse after the final handshake.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE, with these transitions: IDLE->RUN on i_start; RUN->DONE on the handshake of the frame-last coordinate; DONE->IDLE after exactly one cycle.
REQ-017 On i_start in IDLE, the sizes and steps SHALL be latched; input changes after that edge do not affect the running frame.
REQ-018 i_start outside IDLE SHALL be ignored.
REQ-019 If the latched i_dst_width or i_dst_height is 0, start SHALL go IDLE->DONE directly, emit no coordinate, and still pulse o_frame_done.
REQ-020 Accumulators acc_x and acc_y SHALL be W_BITS+4+SCALE_FW bits wide and unsigned, with no overflow possible.
  - Both are 0 at frame start.
  - acc_x += step_x per accepted pixel; it resets to 0 at row end.
  - acc_y += step_y per completed row.
REQ-021 For each axis, let integer part = acc >> SCALE_FW and fraction = acc[SCALE_FW-1:0].
  - If integer part >= src_size-1: o_src = src_size-1 and o_offset = 0 (edge clamp).
  - Otherwise: o_src = integer part and o_offset = fraction.
REQ-022 The first coordinate (0,0, offsets 0) SHALL present o_coord_valid=1 on the edge after i_start is sampled, i.e. with 1-cycle latency.
REQ-023 A handshake SHALL be the condition o_coord_valid & i_coord_ready at a rising edge.
REQ-024 While o_coord_valid=1 and i_coord_ready=0, all coordinate and flag outputs SHALL hold stable.
REQ-025 After each non-final handshake, the next coordinate SHALL be valid on the same edge, so full throughput is 1 coordinate per cycle with no bubbles.
REQ-026 Scan order SHALL be raster: x from 0 to dst_width-1, then y+1.
  - o_line_last=1 when x = dst_width-1.
  - o_frame_last=1 additionally when y = dst_height-1.
REQ-027 o_coord_valid SHALL be 0 in IDLE and DONE; o_frame_done=1 only in DONE.
REQ-028 All outputs SHALL be registered; there is no combinational path from i_coord_ready to any output.

Reset
REQ-029 While rst_n=0, the FSM SHALL be IDLE and every output SHALL be 0; the accumulators and latched configuration SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately: no o_frame_done, and a new i_start is required after release.

Verification
REQ-031 Upscale: src 4x4, dst 8x8, step 0x080 with ready held 1 -> row 0 (x,offset) = (0,0),(0,128),(1,0),(1,128),(2,0),(2,128),(3,0),(3,0 clamped); 64 coordinates; frame_done 1 cycle after the 64th handshake.
REQ-032 Backpressure: same setup, ready toggled 1,0,0,1 -> outputs frozen during ready=0 and no coordinate skipped or repeated.
REQ-033 Downscale: src 8x2, dst 3x1, step 0x2AB -> x = 2,off 0xAB; then 5,off 0x56; frame_last=1 on the third coordinate.
REQ-034 Zero size: dst_width=0 with start -> no valid, o_frame_done=1 on the next cycle, back to IDLE.
REQ-035 Reset mid-frame: rst_n low after 10 handshakes -> all outputs 0 immediately and no frame_done; a restart yields (0,0) first.
REQ-036 Start during RUN and config change after start -> both ignored; the sequence matches the latched configuration.

Source files
------------

// File: rtl/bilinear_coord_generator.sv
// Raster-order destination-to-source coordinate generator for bilinear scaling.
// Emits clamped integer source coordinates and fractional offsets with a valid/ready handshake.
module bilinear_coord_generator #(
    parameter int SCALE_FW = 8,
    parameter int W_BITS   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [W_BITS-1:0]     i_src_width,
    input  logic [W_BITS-1:0]     i_src_height,
    input  logic [W_BITS-1:0]     i_dst_width,
    input  logic [W_BITS-1:0]     i_dst_height,
    input  logic [4+SCALE_FW-1:0] i_step_x,
    input  logic [4+SCALE_FW-1:0] i_step_y,
    input  logic                  i_coord_ready,
    output logic                  o_coord_valid,
    output logic [W_BITS-1:0]     o_src_x,
    output logic [W_BITS-1:0]     o_src_y,
    output logic [SCALE_FW-1:0]   o_offset_x,
    output logic [SCALE_FW-1:0]   o_offset_y,
    output logic                  o_line_last,
    output logic                  o_frame_last,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int STEP_W = 4 + SCALE_FW;
    localparam int ACC_W  = W_BITS + 4 + SCALE_FW;
    localparam int INT_W  = W_BITS + 4;
    localparam int MAP_W  = W_BITS + SCALE_FW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [W_BITS-1:0]     src_w_q, src_w_d, src_h_q, src_h_d;
    logic [W_BITS-1:0]     dst_w_q, dst_w_d, dst_h_q, dst_h_d;
    logic [STEP_W-1:0]     step_x_q, step_x_d, step_y_q, step_y_d;
    logic [ACC_W-1:0]      acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [W_BITS-1:0]     x_q, x_d, y_q, y_d;
    logic                  valid_q, valid_d;
    logic [W_BITS-1:0]     src_x_q, src_x_d, src_y_q, src_y_d;
    logic [SCALE_FW-1:0]   off_x_q, off_x_d, off_y_q, off_y_d;
    logic                  line_last_q, line_last_d, frame_last_q, frame_last_d;
    logic                  busy_q, busy_d, frame_done_q, frame_done_d;
    logic                  handshake;
    logic [MAP_W-1:0]      map_x, map_y;

    // Integer part at or beyond the last source pixel clamps to the edge with zero offset.
    function automatic logic [MAP_W-1:0] map_axis(input logic [ACC_W-1:0]  acc,
                                                  input logic [W_BITS-1:0] src_size);
        logic [INT_W-1:0]  int_part;
        logic [W_BITS-1:0] last;
        int_part = acc[ACC_W-1:SCALE_FW];
        last     = src_size - W_BITS'(1);
        if (int_part >= INT_W'(last))
            return {last, {SCALE_FW{1'b0}}};
        else
            return {int_part[W_BITS-1:0], acc[SCALE_FW-1:0]};
    endfunction

    assign handshake = valid_q & i_coord_ready;

    // Outputs are derived from next-state values so they register alongside the state.
    always_comb begin
        state_d  = state_q;
        src_w_d  = src_w_q;
        src_h_d  = src_h_q;
        dst_w_d  = dst_w_q;
        dst_h_d  = dst_h_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        x_d      = x_q;
        y_d      = y_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    src_w_d  = i_src_width;
                    src_h_d  = i_src_height;
                    dst_w_d  = i_dst_width;
                    dst_h_d  = i_dst_height;
                    step_x_d = i_step_x;
                    step_y_d = i_step_y;
                    acc_x_d  = '0;
                    acc_y_d  = '0;
                    x_d      = '0;
                    y_d      = '0;
                    if (i_dst_width == '0 || i_dst_height == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (handshake) begin
                    if (frame_last_q) begin
                        state_d = S_DONE;
                    end else if (line_last_q) begin
                        x_d     = '0;
                        acc_x_d = '0;
                        y_d     = y_q + W_BITS'(1);
                        acc_y_d = acc_y_q + ACC_W'(step_y_q);
                    end else begin
                        x_d     = x_q + W_BITS'(1);
                        acc_x_d = acc_x_q + ACC_W'(step_x_q);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        map_x        = map_axis(acc_x_d, src_w_d);
        map_y        = map_axis(acc_y_d, src_h_d);
        valid_d      = (state_d == S_RUN);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
        src_x_d      = valid_d ? map_x[MAP_W-1:SCALE_FW] : '0;
        off_x_d      = valid_d ? map_x[SCALE_FW-1:0]     : '0;
        src_y_d      = valid_d ? map_y[MAP_W-1:SCALE_FW] : '0;
        off_y_d      = valid_d ? map_y[SCALE_FW-1:0]     : '0;
        line_last_d  = valid_d && (x_d == dst_w_d - W_BITS'(1));
        frame_last_d = line_last_d && (y_d == dst_h_d - W_BITS'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_w_q      <= '0;
            src_h_q      <= '0;
            dst_w_q      <= '0;
            dst_h_q      <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            valid_q      <= 1'b0;
            src_x_q      <= '0;
            src_y_q      <= '0;
            off_x_q      <= '0;
            off_y_q      <= '0;
            line_last_q  <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_w_q      <= src_w_d;
            src_h_q      <= src_h_d;
            dst_w_q      <= dst_w_d;
            dst_h_q      <= dst_h_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            x_q          <= x_d;
            y_q          <= y_d;
            valid_q      <= valid_d;
            src_x_q      <= src_x_d;
            src_y_q      <= src_y_d;
            off_x_q      <= off_x_d;
            off_y_q      <= off_y_d;
            line_last_q  <= line_last_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_coord_valid = valid_q;
    assign o_src_x       = src_x_q;
    assign o_src_y       = src_y_q;
    assign o_offset_x    = off_x_q;
    assign o_offset_y    = off_y_q;
    assign o_line_last   = line_last_q;
    assign o_frame_last  = frame_last_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_bilinear_coord_generator.sv
// Scoreboard bench for bilinear_coord_generator: stimulus queues expected coordinates,
// a negedge monitor pops and compares on each handshake.
module tb_bilinear_coord_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [11:0] i_src_width = '0, i_src_height = '0, i_dst_width = '0, i_dst_height = '0;
    logic [11:0] i_step_x = '0, i_step_y = '0;
    logic        i_coord_ready = 1'b0;
    logic        o_coord_valid;
    logic [11:0] o_src_x, o_src_y;
    logic [7:0]  o_offset_x, o_offset_y;
    logic        o_line_last, o_frame_last, o_busy, o_frame_done;

    bilinear_coord_generator #(.SCALE_FW(8), .W_BITS(12)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_src_width(i_src_width), .i_src_height(i_src_height),
        .i_dst_width(i_dst_width), .i_dst_height(i_dst_height),
        .i_step_x(i_step_x), .i_step_y(i_step_y), .i_coord_ready(i_coord_ready),
        .o_coord_valid(o_coord_valid), .o_src_x(o_src_x), .o_src_y(o_src_y),
        .o_offset_x(o_offset_x), .o_offset_y(o_offset_y),
        .o_line_last(o_line_last), .o_frame_last(o_frame_last),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] sx;
        logic [11:0] sy;
        logic [7:0]  ox;
        logic [7:0]  oy;
        logic        ll;
        logic        fl;
    } coord_t;

    coord_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     hs_cnt = 0;
    int     frames_done = 0;
    int     ready_mode = 0;
    bit     allow_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic coord_t model(int x, int y, int sw, int sh, int dw, int dh, int stx, int sty);
        coord_t c;
        int ax = x * stx;
        int ay = y * sty;
        if ((ax >> 8) >= sw - 1) begin c.sx = 12'(sw - 1); c.ox = 8'd0; end
        else begin c.sx = 12'(ax >> 8); c.ox = 8'(ax & 255); end
        if ((ay >> 8) >= sh - 1) begin c.sy = 12'(sh - 1); c.oy = 8'd0; end
        else begin c.sy = 12'(ay >> 8); c.oy = 8'(ay & 255); end
        c.ll = (x == dw - 1);
        c.fl = c.ll && (y == dh - 1);
        return c;
    endfunction

    task automatic push_frame(int sw, int sh, int dw, int dh, int stx, int sty, int first_row);
        for (int y = first_row; y < dh; y++)
            for (int x = 0; x < dw; x++)
                exp_q.push_back(model(x, y, sw, sh, dw, dh, stx, sty));
    endtask

    function automatic coord_t mk(int sx, int sy, int ox, int oy, bit ll, bit fl);
        coord_t c;
        c.sx = 12'(sx); c.sy = 12'(sy); c.ox = 8'(ox); c.oy = 8'(oy); c.ll = ll; c.fl = fl;
        return c;
    endfunction

    // Ready changes just after the rising edge so the monitor sees the value the next edge samples.
    initial begin
        int k = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: i_coord_ready = 1'b1;
                1: begin i_coord_ready = pat[k % 4]; k++; end
                default: i_coord_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        coord_t got, snap, e;
        bit stall_prev = 1'b0;
        bit done_due = 1'b0;
        bit done_next;
        forever begin
            @(negedge clk);
            got = {o_src_x, o_src_y, o_offset_x, o_offset_y, o_line_last, o_frame_last};
            if (!rst_n) begin
                stall_prev = 1'b0;
                done_due = 1'b0;
            end else begin
                done_next = 1'b0;
                if (stall_prev) begin
                    chk("hold_valid", 64'(o_coord_valid), 64'd1);
                    chk("hold_outputs", 64'(got), 64'(snap));
                end
                if (done_due) begin
                    chk("frame_done_pulse", 64'({o_frame_done, o_coord_valid, o_busy}), 64'b101);
                    if (o_frame_done) frames_done++;
                end else if (o_frame_done) begin
                    if (allow_done) frames_done++;
                    else chk("unexpected_frame_done", 64'(o_frame_done), 64'd0);
                end
                if (o_coord_valid && i_coord_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_coord", 64'(got), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("coord", 64'(got), 64'(e));
                        hs_cnt++;
                        if (e.fl) done_next = 1'b1;
                    end
                end
                done_due   = done_next;
                stall_prev = o_coord_valid && !i_coord_ready;
                snap       = got;
            end
        end
    end

    task automatic start_frame(int sw, int sh, int dw, int dh, int stx, int sty);
        @(posedge clk);
        #1;
        i_src_width = 12'(sw); i_src_height = 12'(sh);
        i_dst_width = 12'(dw); i_dst_height = 12'(dh);
        i_step_x = 12'(stx); i_step_y = 12'(sty);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int budget);
        int base = frames_done;
        int n = 0;
        while (frames_done == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, 64'(frames_done - base), 64'd1);
        chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base, n;
        #3;
        chk("reset_outputs", 64'({o_coord_valid, o_src_x, o_src_y, o_offset_x, o_offset_y,
                                  o_line_last, o_frame_last, o_busy, o_frame_done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Upscale 4x4 -> 8x8, half-pixel steps; row 0 written out by hand.
        ready_mode = 0;
        exp_q.push_back(mk(0, 0, 0,   0, 0, 0));
        exp_q.push_back(mk(0, 0, 128, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0,   0, 0, 0));
        exp_q.push_back(mk(1, 0, 128, 0, 0, 0));
        exp_q.push_back(mk(2, 0, 0,   0, 0, 0));
        exp_q.push_back(mk(2, 0, 128, 0, 0, 0));
        exp_q.push_back(mk(3, 0, 0,   0, 0, 0));
        exp_q.push_back(mk(3, 0, 0,   0, 1, 0));
        push_frame(4, 4, 8, 8, 'h080, 'h080, 1);
        start_frame(4, 4, 8, 8, 'h080, 'h080);
        chk("first_latency_valid", 64'(o_coord_valid), 64'd1);
        chk("busy_in_run", 64'(o_busy), 64'd1);
        wait_frame("upscale", 200);
        @(posedge clk);
        #2;
        chk("idle_after_done", 64'({o_busy, o_coord_valid, o_frame_done}), 64'd0);

        // Same frame under 1,0,0,1 backpressure.
        ready_mode = 1;
        push_frame(4, 4, 8, 8, 'h080, 'h080, 0);
        start_frame(4, 4, 8, 8, 'h080, 'h080);
        wait_frame("backpressure", 400);

        // Downscale 8x2 -> 3x1 with step 0x2AB.
        ready_mode = 0;
        exp_q.push_back(mk(0, 0, 0,    0, 0, 0));
        exp_q.push_back(mk(2, 0, 'hAB, 0, 0, 0));
        exp_q.push_back(mk(5, 0, 'h56, 0, 1, 1));
        start_frame(8, 2, 3, 1, 'h2AB, 'h100);
        wait_frame("downscale", 50);

        // Zero destination width: straight to DONE, no coordinates.
        allow_done = 1'b1;
        base = frames_done;
        start_frame(4, 4, 0, 5, 'h100, 'h100);
        chk("zero_done", 64'({o_frame_done, o_coord_valid, o_busy}), 64'b101);
        @(posedge clk);
        #1;
        chk("zero_back_idle", 64'({o_frame_done, o_coord_valid, o_busy}), 64'd0);
        @(negedge clk);
        chk("zero_done_count", 64'(frames_done - base), 64'd1);
        allow_done = 1'b0;

        // Reset after 10 handshakes aborts the frame.
        push_frame(4, 4, 8, 8, 'h080, 'h080, 0);
        base = hs_cnt;
        start_frame(4, 4, 8, 8, 'h080, 'h080);
        n = 0;
        while (hs_cnt < base + 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_wait_10_hs", 64'(hs_cnt - base), 64'd10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", 64'({o_coord_valid, o_src_x, o_src_y, o_offset_x, o_offset_y,
                                           o_line_last, o_frame_last, o_busy, o_frame_done}), 64'd0);
        exp_q.delete();
        base = frames_done;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_done_after_abort", 64'(frames_done - base), 64'd0);
        chk("idle_after_abort", 64'({o_coord_valid, o_busy}), 64'd0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        push_frame(8, 2, 3, 1, 'h2AB, 'h100, 0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        exp_q.push_back(mk(2, 0, 'hAB, 0, 0, 0));
        exp_q.push_back(mk(5, 0, 'h56, 0, 1, 1));
        start_frame(8, 2, 3, 1, 'h2AB, 'h100);
        wait_frame("restart", 50);

        // Config changes and extra starts while running are ignored.
        ready_mode = 2;
        push_frame(4, 4, 3, 2, 'h155, 'h200, 0);
        start_frame(4, 4, 3, 2, 'h155, 'h200);
        i_src_width = 12'd100; i_src_height = 12'd100;
        i_dst_width = 12'd9;   i_dst_height = 12'd9;
        i_step_x = 12'h040;    i_step_y = 12'h040;
        i_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_frame("ignore_start", 200);
        ready_mode = 0;

        repeat (4) @(negedge clk);
        chk("final_idle", 64'({o_coord_valid, o_busy, o_frame_done}), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
